// File: rtl/char_msg_writer.sv
// -----------------------------------------------------------------------------
// char_msg_writer
//
// Fills the character buffer that the text-overlay stage reads. Two requesters
// share the buffer write port through a round-robin arbiter. Each granted job
// optionally clears the whole buffer to CLR_CHAR, then copies a zero-terminated
// string (at most MAX_LEN bytes) from the message ROM, starting at a given cell.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req0/msg_id0/pos0/clr0  requester 0: level request, message index,
//                       start cell {row[3:0], col[4:0]}, clear-before-copy
//   req1/msg_id1/pos1/clr1  same fields for requester 1
//   grant               one-hot owner of the current job, 00 when idle
//   busy                job in progress
//   done                one-cycle pulse at job end
//   rom_addr            {msg_id, char_index} to the message ROM
//   rom_data            ROM output, valid one cycle after rom_addr
//   buf_we/buf_addr/buf_data  character buffer write port
//
// All outputs are registered. Every state computes the outputs for the cycle
// that follows it, so a byte sampled in WR is written during the next cycle.
// When the last of MAX_LEN characters is copied, that write and the done
// pulse share a cycle.
// -----------------------------------------------------------------------------
module char_msg_writer #(
    parameter int         MAX_LEN   = 32,
    parameter logic [7:0] CLR_CHAR  = 8'h20,
    parameter int         BUF_CELLS = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] msg_id0,
    input  logic [8:0] pos0,
    input  logic       clr0,
    input  logic       req1,
    input  logic [3:0] msg_id1,
    input  logic [8:0] pos1,
    input  logic       clr1,
    output logic [1:0] grant,
    output logic       busy,
    output logic       done,
    output logic [8:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       buf_we,
    output logic [8:0] buf_addr,
    output logic [7:0] buf_data
);

    localparam int                 SLOT_W    = $clog2(MAX_LEN);
    localparam int                 IDX_W     = $clog2(MAX_LEN + 1);
    localparam logic [IDX_W-1:0]   IDX_END   = IDX_W'(MAX_LEN);
    localparam logic [8:0]         LAST_CELL = 9'(BUF_CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             buf_we_q, buf_we_d;
    logic [8:0]       buf_addr_q, buf_addr_d;
    logic [7:0]       buf_data_q, buf_data_d;
    logic [8:0]       rom_addr_q, rom_addr_d;
    logic             last_grant_q, last_grant_d;  // index of the previous owner
    logic             owner_q, owner_d;            // index of the current owner
    logic [3:0]       msg_q, msg_d;
    logic [8:0]       pos_q, pos_d;
    logic [IDX_W-1:0] char_idx_q, char_idx_d;

    logic             pick;
    logic             pick_clr;
    logic [IDX_W-1:0] next_idx;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        buf_we_d     = 1'b0;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        rom_addr_d   = rom_addr_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        msg_d        = msg_q;
        pos_d        = pos_q;
        char_idx_d   = char_idx_q;
        pick         = 1'b0;
        pick_clr     = 1'b0;
        next_idx     = char_idx_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not own the last job wins.
                    pick       = (req0 && req1) ? ~last_grant_q : req1;
                    owner_d    = pick;
                    grant_d    = pick ? 2'b10 : 2'b01;
                    busy_d     = 1'b1;
                    msg_d      = pick ? msg_id1 : msg_id0;
                    pos_d      = pick ? pos1 : pos0;
                    pick_clr   = pick ? clr1 : clr0;
                    char_idx_d = '0;
                    if (pick_clr) begin
                        state_d    = S_CLEAR;
                        buf_we_d   = 1'b1;
                        buf_addr_d = '0;
                        buf_data_d = CLR_CHAR;
                    end else begin
                        state_d    = S_RD;
                        rom_addr_d = {msg_d, {SLOT_W{1'b0}}};
                    end
                end
            end

            S_CLEAR: begin
                // buf_addr_q is the cell being written this cycle.
                if (buf_addr_q == LAST_CELL) begin
                    state_d    = S_RD;
                    rom_addr_d = {msg_q, char_idx_q[SLOT_W-1:0]};
                end else begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = buf_addr_q + 9'd1;
                    buf_data_d = CLR_CHAR;
                end
            end

            S_RD: begin
                // rom_addr was loaded on entry; the ROM answers during WR.
                state_d = S_WR;
            end

            S_WR: begin
                if (rom_data == 8'h00) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    buf_we_d   = 1'b1;
                    buf_addr_d = pos_q + 9'(char_idx_q);  // 9-bit wrap is intended
                    buf_data_d = rom_data;
                    char_idx_d = next_idx;
                    if (next_idx == IDX_END) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_RD;
                        rom_addr_d = {msg_q, next_idx[SLOT_W-1:0]};
                    end
                end
            end

            S_DONE: begin
                state_d      = S_IDLE;
                grant_d      = 2'b00;
                busy_d       = 1'b0;
                last_grant_d = owner_q;
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            rom_addr_q   <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            msg_q        <= '0;
            pos_q        <= '0;
            char_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            buf_we_q     <= buf_we_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            rom_addr_q   <= rom_addr_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            msg_q        <= msg_d;
            pos_q        <= pos_d;
            char_idx_q   <= char_idx_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = rom_addr_q;
    assign buf_we   = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign buf_data = buf_data_q;

endmodule

// File: tb/tb_char_msg_writer.sv
// -----------------------------------------------------------------------------
// tb_char_msg_writer
//
// Bench for char_msg_writer. A job-level model predicts, per granted job, the
// owner, the full list of buffer writes, and the grant-to-done latency
// (512 cycles per clear plus 2 per character and 2 for the terminator, or
// 2*MAX_LEN for an unterminated slot). One negedge process checks the DUT
// against that model every cycle; directed jobs also pin literal results.
// -----------------------------------------------------------------------------
module tb_char_msg_writer;

    localparam int MAX_LEN = 32;

    typedef struct packed {
        logic [8:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] msg_id0 = '0, msg_id1 = '0;
    logic [8:0] pos0 = '0, pos1 = '0;
    logic       clr0 = 1'b0, clr1 = 1'b0;
    logic [1:0] grant;
    logic       busy, done, buf_we;
    logic [8:0] rom_addr, buf_addr;
    logic [7:0] rom_data, buf_data;

    logic [7:0] rom [0:511];

    always #5 clk = ~clk;

    char_msg_writer dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .msg_id0 (msg_id0),
        .pos0    (pos0),
        .clr0    (clr0),
        .req1    (req1),
        .msg_id1 (msg_id1),
        .pos1    (pos1),
        .clr1    (clr1),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .buf_we  (buf_we),
        .buf_addr(buf_addr),
        .buf_data(buf_data)
    );

    // Synchronous message ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    endfunction

    task automatic finish_tb();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        $display("FAIL %s: got no event, want one within budget (t=%0t)", nm, $time);
        finish_tb();
    endtask

    // ---------------- behavioural model ----------------
    wr_t        exp_q[$];
    wr_t        obs_q[$];
    int         owner_log[$];
    int         m_owner = -1;
    logic       m_last  = 1'b1;
    logic       m_cool  = 1'b1;
    int         m_cyc, m_len, m_base, m_nchars, m_chars;
    logic [3:0] m_msg;
    logic       s_req0 = 1'b0, s_req1 = 1'b0, s_clr0 = 1'b0, s_clr1 = 1'b0;
    logic [3:0] s_id0 = '0, s_id1 = '0;
    logic [8:0] s_pos0 = '0, s_pos1 = '0;

    function automatic void build_job(input logic [3:0] id, input logic [8:0] p, input logic c);
        int n;
        exp_q.delete();
        if (c) for (int i = 0; i < 512; i++) exp_q.push_back({9'(i), 8'h20});
        n = 0;
        while (n < MAX_LEN && rom[int'(id) * MAX_LEN + n] != 8'h00) begin
            exp_q.push_back({9'(int'(p) + n), rom[int'(id) * MAX_LEN + n]});
            n++;
        end
        m_nchars = n;
        m_msg    = id;
        m_base   = c ? 512 : 0;
        m_len    = m_base + ((n < MAX_LEN) ? 2 * (n + 1) : 2 * MAX_LEN);
    endfunction

    always @(negedge clk) begin
        logic [1:0] e_grant;
        logic       e_done, e_we;
        int         rel;
        if (!rst) begin
            chk("reset_outputs", {grant, busy, done, buf_we, buf_addr, buf_data, rom_addr}, '0);
            exp_q.delete();
            m_owner = -1;
            m_last  = 1'b1;
            m_cool  = 1'b1;  // the first cycle after release is always idle
        end else begin
            if (m_owner < 0) begin
                if (m_cool) m_cool = 1'b0;
                else if (s_req0 || s_req1) begin
                    m_owner = (s_req0 && s_req1) ? (m_last ? 0 : 1) : (s_req1 ? 1 : 0);
                    if (m_owner == 1) build_job(s_id1, s_pos1, s_clr1);
                    else              build_job(s_id0, s_pos0, s_clr0);
                    m_cyc   = 0;
                    m_chars = 0;
                    obs_q.delete();
                    owner_log.push_back(m_owner);
                end
            end else m_cyc++;

            e_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
            e_done  = (m_owner >= 0) && (m_cyc == m_len);
            rel     = m_cyc - m_base;
            e_we    = (m_owner >= 0) &&
                      ((m_base != 0 && m_cyc < 512) ||
                       (rel >= 2 && rel % 2 == 0 && rel / 2 <= m_nchars));

            chk("grant", grant, e_grant);
            chk("busy", busy, m_owner >= 0);
            chk("done", done, e_done);
            chk("buf_we", buf_we, e_we);
            if (buf_we === 1'b1) begin
                obs_q.push_back({buf_addr, buf_data});
                if (exp_q.size() > 0) begin
                    chk("buf_write", {buf_addr, buf_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                    if (m_cyc >= m_base) m_chars++;
                end
            end
            if (m_owner >= 0 && !e_done && m_cyc >= m_base)
                chk("rom_addr", rom_addr, {m_msg, 5'(m_chars)});
            if (e_done) begin
                chk("writes_left", exp_q.size(), 0);
                m_last  = m_owner[0];
                m_owner = -1;
                m_cool  = 1'b1;
            end
        end
        s_req0 = req0; s_id0 = msg_id0; s_pos0 = pos0; s_clr0 = clr0;
        s_req1 = req1; s_id1 = msg_id1; s_pos1 = pos1; s_clr1 = clr1;
    end

    // Any ROM access to slot 8 while the full slot-7 message runs means the
    // copy ran past MAX_LEN.
    bit mon_en = 0;
    int slot8_hits = 0;
    always @(posedge clk) if (mon_en && busy && rom_addr[8:5] == 4'd8) slot8_hits++;

    // ---------------- stimulus ----------------
    task automatic wait_for(input bit want_done, input int budget, input string nm);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (want_done ? (done === 1'b1) : (grant !== 2'b00)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout(nm);
    endtask

    task automatic run_job(input int r, input logic [3:0] id, input logic [8:0] p,
                           input logic c, output int lat);
        int tg;
        if (r == 0) begin msg_id0 = id; pos0 = p; clr0 = c; req0 = 1'b1; end
        else        begin msg_id1 = id; pos1 = p; clr1 = c; req1 = 1'b1; end
        wait_for(0, 20, "grant_wait");
        tg = cyc;
        wait_for(1, 1500, "done_wait");
        lat = cyc - tg;
        if (r == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        int lat, base, tg, extra, len;
        logic [1:0] g;

        for (int s = 0; s < 16; s++) begin
            len = $urandom_range(0, MAX_LEN);
            for (int k = 0; k < MAX_LEN; k++)
                rom[s * MAX_LEN + k] = (k < len) ? 8'($urandom_range(1, 255)) : 8'h00;
        end
        rom[0] = 8'h00;                                            // empty message
        rom[1*32+0] = "A"; rom[1*32+1] = "B"; rom[1*32+2] = 8'h00;
        rom[2*32+0] = "X"; rom[2*32+1] = "Y"; rom[2*32+2] = "Z"; rom[2*32+3] = 8'h00;
        rom[3*32+0] = "G"; rom[3*32+1] = "O"; rom[3*32+2] = 8'h00;
        rom[5*32+0] = "W"; rom[5*32+1] = "I"; rom[5*32+2] = "N"; rom[5*32+3] = 8'h00;
        for (int k = 0; k < MAX_LEN; k++) begin
            rom[7*32+k] = 8'($urandom_range(1, 255));
            rom[8*32+k] = 8'($urandom_range(1, 255));
        end

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset in the middle of a clear.
        msg_id1 = 4'd5; pos1 = 9'h1FF; clr1 = 1'b1; req1 = 1'b1;
        begin
            bit ok = 0;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk); #1;
                if (buf_we === 1'b1 && buf_addr == 9'd100) begin ok = 1; break; end
            end
            if (!ok) timeout("clear_reach_100");
        end
        rst = 1'b0; req1 = 1'b0; clr1 = 1'b0;
        #1 chk("async_reset_outputs", {grant, busy, done, buf_we, buf_addr, buf_data, rom_addr}, '0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // "GO" at 0x045, no clear.
        run_job(0, 4'd3, 9'h045, 1'b0, lat);
        chk("go_latency", lat, 6);
        chk("go_nwrites", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            chk("go_w0", obs_q[0], {9'h045, 8'h47});
            chk("go_w1", obs_q[1], {9'h046, 8'h4F});
        end
        chk("go_owner", owner_log[owner_log.size()-1], 0);

        // "WIN" at 0x1FF with clear; characters wrap past cell 511.
        run_job(1, 4'd5, 9'h1FF, 1'b1, lat);
        chk("win_latency", lat, 520);
        chk("win_nwrites", obs_q.size(), 515);
        if (obs_q.size() >= 515) begin
            chk("win_clr_first", obs_q[0],   {9'h000, 8'h20});
            chk("win_clr_last",  obs_q[511], {9'h1FF, 8'h20});
            chk("win_w",         obs_q[512], {9'h1FF, 8'h57});
            chk("win_i_wrap",    obs_q[513], {9'h000, 8'h49});
            chk("win_n",         obs_q[514], {9'h001, 8'h4E});
        end
        chk("win_owner", owner_log[owner_log.size()-1], 1);

        // Both requesters held from reset: strict alternation starting with 0.
        rst = 1'b0;
        msg_id0 = 4'd3; pos0 = 9'h080; clr0 = 1'b0; req0 = 1'b1;
        msg_id1 = 4'd1; pos1 = 9'h0C0; clr1 = 1'b0; req1 = 1'b1;
        base = owner_log.size();
        @(posedge clk); #1 rst = 1'b1;
        for (int j = 0; j < 4; j++) wait_for(1, 100, "alt_done");
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk); #1;
        chk("alt_jobs", owner_log.size() - base, 4);
        if (owner_log.size() - base >= 4)
            for (int j = 0; j < 4; j++) chk("alt_owner", owner_log[base + j], j % 2);

        // Unterminated 32-byte slot: exactly MAX_LEN writes, slot 8 never read.
        mon_en = 1;
        run_job(0, 4'd7, 9'h100, 1'b0, lat);
        mon_en = 0;
        chk("full_latency", lat, 64);
        chk("full_nwrites", obs_q.size(), 32);
        if (obs_q.size() >= 32) chk("full_last", obs_q[31], {9'h11F, rom[7*32+31]});
        chk("full_no_overrun", slot8_hits, 0);

        // Request dropped and fields changed one cycle after grant.
        msg_id0 = 4'd1; pos0 = 9'h020; clr0 = 1'b0; req0 = 1'b1;
        wait_for(0, 20, "latch_grant");
        tg = cyc;
        req0 = 1'b0; msg_id0 = 4'd2; pos0 = 9'h150; clr0 = 1'b1;
        wait_for(1, 200, "latch_done");
        chk("latch_latency", cyc - tg, 6);
        @(negedge clk); #1;
        chk("latch_nwrites", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            chk("latch_w0", obs_q[0], {9'h020, 8'h41});
            chk("latch_w1", obs_q[1], {9'h021, 8'h42});
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        chk("latch_single_done", extra, 0);

        // Random traffic; each requester drops its req when its job finishes.
        for (int it = 0; it < 80; it++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin
                msg_id0 = 4'($urandom_range(0, 15)); pos0 = 9'($urandom);
                clr0 = ($urandom_range(0, 15) == 0); req0 = 1'b1;
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                msg_id1 = 4'($urandom_range(0, 15)); pos1 = 9'($urandom);
                clr1 = ($urandom_range(0, 15) == 0); req1 = 1'b1;
            end
            if (!req0 && !req1) begin
                msg_id0 = 4'($urandom_range(0, 15)); pos0 = 9'($urandom);
                clr0 = 1'b0; req0 = 1'b1;
            end
            wait_for(1, 1500, "rand_done");
            g = grant;
            if (g[0]) req0 = 1'b0;
            if (g[1]) req1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (1200) begin
            @(posedge clk);
            if (!busy) break;
        end
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        finish_tb();
    end

endmodule
